// File: rtl/riscv_pkg.sv
// Shared decode constants, immediate formats and the DE->EXE bundle.
// Imported by every stage of the core.
package riscv_pkg;

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  localparam int CST_LOAD   = 3;
  localparam int CST_STORE  = 2;
  localparam int CST_BRANCH = 1;
  localparam int CST_JUMP   = 0;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  typedef struct packed {
    logic        v;
    logic [31:0] ir;
    logic [63:0] npc;
    logic [63:0] alu1;
    logic [63:0] alu2;
    logic [63:0] addr;
    logic [63:0] tgt;
    logic [3:0]  cst;
  } de_ex_t;

  function automatic logic [63:0] imm_gen(
    input logic [31:0] ir,
    input imm_fmt_e    fmt
  );
    logic [63:0] imm;
    unique case (fmt)
      IMM_I: imm = {{52{ir[31]}}, ir[31:20]};
      IMM_S: imm = {{52{ir[31]}}, ir[31:25], ir[11:7]};
      IMM_B: imm = {{51{ir[31]}}, ir[31], ir[7],
                    ir[30:25], ir[11:8], 1'b0};
      IMM_U: imm = {{32{ir[31]}}, ir[31:12], 12'b0};
      IMM_J: imm = {{43{ir[31]}}, ir[31], ir[19:12],
                    ir[20], ir[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

  function automatic logic hazard(
    input logic [4:0] rs,
    input logic [4:0] exe_dr,
    input logic [4:0] mem_dr
  );
    return (rs != 5'd0) && ((rs == exe_dr) || (rs == mem_dr));
  endfunction

endpackage

// File: rtl/decode_unit_if.sv
// DE-side inputs, writeback port and EXE latch outputs of decode_unit.
// master drives the DE latch and writeback; slave is the decode side.
interface decode_unit_if;

  logic [63:0] de_npc;
  logic [31:0] de_ir;
  logic        de_v;
  logic        wb_wen;
  logic [4:0]  wb_dr;
  logic [63:0] wb_data;
  logic [4:0]  exe_dr;
  logic [4:0]  mem_dr;
  logic        exe_v;
  logic [31:0] exe_ir;
  logic [63:0] exe_npc;
  logic [63:0] exe_alu1;
  logic [63:0] exe_alu2;
  logic [63:0] exe_addr;
  logic [63:0] exe_tgt;
  logic [3:0]  exe_cst;
  logic        de_stall;
  logic        br_stall;

  modport master (
    output de_npc, de_ir, de_v,
    output wb_wen, wb_dr, wb_data,
    output exe_dr, mem_dr,
    input  exe_v, exe_ir, exe_npc,
    input  exe_alu1, exe_alu2,
    input  exe_addr, exe_tgt, exe_cst,
    input  de_stall, br_stall
  );

  modport slave (
    input  de_npc, de_ir, de_v,
    input  wb_wen, wb_dr, wb_data,
    input  exe_dr, mem_dr,
    output exe_v, exe_ir, exe_npc,
    output exe_alu1, exe_alu2,
    output exe_addr, exe_tgt, exe_cst,
    output de_stall, br_stall
  );

endinterface

// File: rtl/regfile.sv
// 32x64 integer register file: two async read ports with write-through,
// one write port, x0 hardwired to zero, synchronous clear.
module regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [63:0] rd1,
  output logic [63:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [63:0] wd
);

  logic [63:0] regs_q [32];
  logic [63:0] regs_d [32];
  logic        wr_en;

  assign wr_en = we && (wa != 5'd0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[wa] = wd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  function automatic logic [63:0] rd_port(input logic [4:0] ra);
    if (ra == 5'd0) return '0;
    if (wr_en && (wa == ra)) return wd;
    return regs_q[ra];
  endfunction

  assign rd1 = rd_port(ra1);
  assign rd2 = rd_port(ra2);

endmodule

// File: rtl/decode_unit.sv
// RV64 decode stage: register read, immediate decode, RAW stall
// against EXE/MEM, operand selection and the EXE pipeline latch.
module decode_unit
  import riscv_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic [63:0] DE_NPC,
  input  logic [31:0] DE_IR,
  input  logic        DE_V,
  input  logic        OUT_FE_REG_WEN,
  input  logic [4:0]  OUT_DE_DR,
  input  logic [63:0] OUT_DE_Data,
  input  logic [4:0]  EXE_DR,
  input  logic [4:0]  MEM_DR,
  output logic        EXE_V,
  output logic [31:0] EXE_IR,
  output logic [63:0] EXE_NPC,
  output logic [63:0] EXE_ALU1,
  output logic [63:0] EXE_ALU2,
  output logic [63:0] EXE_Address,
  output logic [63:0] EXE_Target_Address,
  output logic [3:0]  EXE_Cst,
  output logic        DE_STALL,
  output logic        V_DE_FE_BR_STALL
);

  logic [6:0]  opc;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [63:0] rs1_val;
  logic [63:0] rs2_val;
  logic [63:0] imm;
  logic [63:0] pc;
  logic        legal;
  logic        use1;
  logic        use2;
  imm_fmt_e    fmt;
  logic        is_lui;
  logic        is_auipc;
  logic        is_jal;
  logic        is_jalr;
  logic        is_br;
  logic        is_ld;
  logic        is_st;
  logic        is_rr;
  logic        stall;
  de_ex_t      exe_d;
  de_ex_t      exe_q;

  assign opc = DE_IR[6:0];
  assign rs1 = DE_IR[19:15];
  assign rs2 = DE_IR[24:20];
  assign pc  = DE_NPC - 64'd4;
  assign imm = imm_gen(DE_IR, fmt);

  regfile u_rf (
    .clk (CLK),
    .rst (RESET),
    .ra1 (rs1),
    .ra2 (rs2),
    .rd1 (rs1_val),
    .rd2 (rs2_val),
    .we  (OUT_FE_REG_WEN),
    .wa  (OUT_DE_DR),
    .wd  (OUT_DE_Data)
  );

  always_comb begin
    legal    = 1'b0;
    use1     = 1'b0;
    use2     = 1'b0;
    fmt      = IMM_NONE;
    is_lui   = 1'b0;
    is_auipc = 1'b0;
    is_jal   = 1'b0;
    is_jalr  = 1'b0;
    is_br    = 1'b0;
    is_ld    = 1'b0;
    is_st    = 1'b0;
    is_rr    = 1'b0;
    unique case (opc)
      OPC_LUI: begin
        legal = 1'b1; is_lui = 1'b1; fmt = IMM_U;
      end
      OPC_AUIPC: begin
        legal = 1'b1; is_auipc = 1'b1; fmt = IMM_U;
      end
      OPC_JAL: begin
        legal = 1'b1; is_jal = 1'b1; fmt = IMM_J;
      end
      OPC_JALR: begin
        legal = 1'b1; is_jalr = 1'b1; fmt = IMM_I;
        use1  = 1'b1;
      end
      OPC_BRANCH: begin
        legal = 1'b1; is_br = 1'b1; fmt = IMM_B;
        use1  = 1'b1; use2 = 1'b1;
      end
      OPC_LOAD: begin
        legal = 1'b1; is_ld = 1'b1; fmt = IMM_I;
        use1  = 1'b1;
      end
      OPC_STORE: begin
        legal = 1'b1; is_st = 1'b1; fmt = IMM_S;
        use1  = 1'b1; use2 = 1'b1;
      end
      OPC_OP_IMM, OPC_OP_IMM_32: begin
        legal = 1'b1; fmt = IMM_I;
        use1  = 1'b1;
      end
      OPC_OP, OPC_OP_32: begin
        legal = 1'b1; is_rr = 1'b1;
        use1  = 1'b1; use2 = 1'b1;
      end
      default: ;
    endcase
  end

  // Writeback hazards are absorbed by the regfile bypass, so only EXE/MEM stall.
  assign stall = ~RESET & DE_V &
                 ((use1 & hazard(rs1, EXE_DR, MEM_DR)) |
                  (use2 & hazard(rs2, EXE_DR, MEM_DR)));

  assign DE_STALL         = stall;
  assign V_DE_FE_BR_STALL = DE_V & (is_br | is_jal | is_jalr);

  always_comb begin
    exe_d     = '0;
    exe_d.v   = DE_V & legal & ~stall;
    exe_d.ir  = DE_IR;
    exe_d.npc = DE_NPC;
    unique case (1'b1)
      is_auipc | is_jal | is_jalr: exe_d.alu1 = pc;
      is_lui:                      exe_d.alu1 = '0;
      default:                     exe_d.alu1 = rs1_val;
    endcase
    unique case (1'b1)
      is_rr | is_br:     exe_d.alu2 = rs2_val;
      is_jal | is_jalr:  exe_d.alu2 = 64'd4;
      default:           exe_d.alu2 = imm;
    endcase
    unique case (1'b1)
      is_st:   exe_d.addr = rs2_val;
      is_ld:   exe_d.addr = rs1_val + imm;
      default: exe_d.addr = '0;
    endcase
    unique case (1'b1)
      is_br | is_jal: exe_d.tgt = pc + imm;
      is_jalr:        exe_d.tgt = (rs1_val + imm) & ~64'd1;
      default:        exe_d.tgt = '0;
    endcase
    exe_d.cst[CST_LOAD]   = exe_d.v & is_ld;
    exe_d.cst[CST_STORE]  = exe_d.v & is_st;
    exe_d.cst[CST_BRANCH] = exe_d.v & is_br;
    exe_d.cst[CST_JUMP]   = exe_d.v & (is_jal | is_jalr);
  end

  always_ff @(posedge CLK) begin
    if (RESET) exe_q <= '0;
    else       exe_q <= exe_d;
  end

  assign EXE_V              = exe_q.v;
  assign EXE_IR             = exe_q.ir;
  assign EXE_NPC            = exe_q.npc;
  assign EXE_ALU1           = exe_q.alu1;
  assign EXE_ALU2           = exe_q.alu2;
  assign EXE_Address        = exe_q.addr;
  assign EXE_Target_Address = exe_q.tgt;
  assign EXE_Cst            = exe_q.cst;

endmodule

// File: tb/tb_decode_unit.sv
// Scoreboard bench for decode_unit: instructions built from fields,
// expected EXE latch derived from the fields and a register array.
module tb_decode_unit;
  import riscv_pkg::*;

  typedef enum int {
    K_LUI, K_AUIPC, K_JAL, K_JALR, K_BR, K_LD,
    K_ST, K_OPI, K_OP, K_OPIW, K_OPW, K_ILL
  } kind_e;

  typedef struct {
    kind_e       k;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [63:0] imm;
  } ins_t;

  typedef struct {
    string       tag;
    logic        chk_f;
    logic        chk_addr;
    logic        chk_tgt;
    logic        stall;
    logic        brs;
    logic        v;
    logic [3:0]  cst;
    logic [31:0] ir;
    logic [63:0] npc;
    logic [63:0] alu1;
    logic [63:0] alu2;
    logic [63:0] addr;
    logic [63:0] tgt;
  } exp_t;

  logic CLK = 1'b0;
  logic RESET;
  decode_unit_if ifc ();

  exp_t        sb [$];
  logic [63:0] rf [32];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [6:0]  ill_ops [4];

  always #5 CLK = ~CLK;

  decode_unit dut (
    .CLK                (CLK),
    .RESET              (RESET),
    .DE_NPC             (ifc.de_npc),
    .DE_IR              (ifc.de_ir),
    .DE_V               (ifc.de_v),
    .OUT_FE_REG_WEN     (ifc.wb_wen),
    .OUT_DE_DR          (ifc.wb_dr),
    .OUT_DE_Data        (ifc.wb_data),
    .EXE_DR             (ifc.exe_dr),
    .MEM_DR             (ifc.mem_dr),
    .EXE_V              (ifc.exe_v),
    .EXE_IR             (ifc.exe_ir),
    .EXE_NPC            (ifc.exe_npc),
    .EXE_ALU1           (ifc.exe_alu1),
    .EXE_ALU2           (ifc.exe_alu2),
    .EXE_Address        (ifc.exe_addr),
    .EXE_Target_Address (ifc.exe_tgt),
    .EXE_Cst            (ifc.exe_cst),
    .DE_STALL           (ifc.de_stall),
    .V_DE_FE_BR_STALL   (ifc.br_stall)
  );

  function automatic logic [31:0] encode(ins_t i, logic [6:0] illop);
    logic [63:0] m;
    m = i.imm;
    case (i.k)
      K_LUI:   return {m[31:12], i.rd, OPC_LUI};
      K_AUIPC: return {m[31:12], i.rd, OPC_AUIPC};
      K_JAL:   return {m[20], m[10:1], m[11], m[19:12], i.rd, OPC_JAL};
      K_JALR:  return {m[11:0], i.rs1, 3'b000, i.rd, OPC_JALR};
      K_BR:    return {m[12], m[10:5], i.rs2, i.rs1, 3'b000,
                       m[4:1], m[11], OPC_BRANCH};
      K_LD:    return {m[11:0], i.rs1, 3'b011, i.rd, OPC_LOAD};
      K_ST:    return {m[11:5], i.rs2, i.rs1, 3'b011, m[4:0], OPC_STORE};
      K_OPI:   return {m[11:0], i.rs1, 3'b000, i.rd, OPC_OP_IMM};
      K_OPIW:  return {m[11:0], i.rs1, 3'b000, i.rd, OPC_OP_IMM_32};
      K_OP:    return {7'b0, i.rs2, i.rs1, 3'b000, i.rd, OPC_OP};
      K_OPW:   return {7'b0, i.rs2, i.rs1, 3'b000, i.rd, OPC_OP_32};
      default: return {m[24:0], illop};
    endcase
  endfunction

  function automatic logic [63:0] rand_imm(kind_e k);
    logic [11:0] r12;
    logic [19:0] r20;
    r12 = 12'($urandom);
    r20 = 20'($urandom);
    case (k)
      K_BR:           return {{51{r12[11]}}, r12, 1'b0};
      K_LUI, K_AUIPC: return {{32{r20[19]}}, r20, 12'b0};
      K_JAL:          return {{43{r20[19]}}, r20, 1'b0};
      default:        return {{52{r12[11]}}, r12};
    endcase
  endfunction

  function automatic logic [4:0] rr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  function automatic logic [63:0] src(logic [4:0] r, logic wen,
                                      logic [4:0] dr, logic [63:0] d);
    if (r == 5'd0) return '0;
    if (wen && dr == r) return d;
    return rf[r];
  endfunction

  task automatic issue(
    input logic        rst,
    input logic        v,
    input ins_t        in,
    input logic [63:0] npc,
    input logic        wen,
    input logic [4:0]  dr,
    input logic [63:0] data,
    input logic [4:0]  edr,
    input logic [4:0]  mdr,
    input string       tag,
    input logic [6:0]  illop = 7'b1111111
  );
    exp_t        e;
    logic        u1, u2;
    logic [63:0] a, b, pc;
    @(negedge CLK);
    RESET       = rst;
    ifc.de_v    = v;
    ifc.de_ir   = encode(in, illop);
    ifc.de_npc  = npc;
    ifc.wb_wen  = wen;
    ifc.wb_dr   = dr;
    ifc.wb_data = data;
    ifc.exe_dr  = edr;
    ifc.mem_dr  = mdr;
    u1 = in.k inside {K_JALR, K_BR, K_LD, K_ST, K_OPI, K_OP, K_OPIW, K_OPW};
    u2 = in.k inside {K_BR, K_ST, K_OP, K_OPW};
    pc = npc - 64'd4;
    a  = src(in.rs1, wen, dr, data);
    b  = src(in.rs2, wen, dr, data);
    e = '{tag: tag, chk_f: 1'b1, chk_addr: 1'b1, chk_tgt: 1'b1,
          stall: 1'b0, brs: 1'b0, v: 1'b0, cst: 4'd0, ir: 32'd0,
          npc: 64'd0, alu1: 64'd0, alu2: 64'd0, addr: 64'd0, tgt: 64'd0};
    e.brs = v && (in.k inside {K_BR, K_JAL, K_JALR});
    if (!rst) begin
      e.stall = v && ((u1 && in.rs1 != 0 && (in.rs1 == edr || in.rs1 == mdr)) ||
                      (u2 && in.rs2 != 0 && (in.rs2 == edr || in.rs2 == mdr)));
      e.v     = v && in.k != K_ILL && !e.stall;
      e.chk_f = e.v;
      if (e.v) e.cst = {in.k == K_LD, in.k == K_ST, in.k == K_BR,
                        in.k == K_JAL || in.k == K_JALR};
      e.ir  = ifc.de_ir;
      e.npc = npc;
      case (in.k)
        K_AUIPC, K_JAL, K_JALR: e.alu1 = pc;
        K_LUI:                  e.alu1 = 64'd0;
        default:                e.alu1 = a;
      endcase
      case (in.k)
        K_OP, K_OPW, K_BR: e.alu2 = b;
        K_JAL, K_JALR:     e.alu2 = 64'd4;
        default:           e.alu2 = in.imm;
      endcase
      e.chk_addr = e.v && (in.k inside {K_LD, K_ST});
      e.addr     = (in.k == K_ST) ? b : a + in.imm;
      e.chk_tgt  = e.v && (in.k inside {K_BR, K_JAL, K_JALR});
      e.tgt      = (in.k == K_JALR) ? ((a + in.imm) & ~64'd1) : pc + in.imm;
    end
    sb.push_back(e);
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] = '0;
    end else if (wen && dr != 0) begin
      rf[dr] = data;
    end
  endtask

  task automatic check(string tag, string name,
                       logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s got=%h expected=%h", tag, name, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check(e.tag, "exe_v", 64'(ifc.exe_v), 64'(e.v));
        check(e.tag, "exe_cst", 64'(ifc.exe_cst), 64'(e.cst));
        check(e.tag, "de_stall", 64'(ifc.de_stall), 64'(e.stall));
        check(e.tag, "br_stall", 64'(ifc.br_stall), 64'(e.brs));
        if (e.chk_f) begin
          check(e.tag, "exe_ir", 64'(ifc.exe_ir), 64'(e.ir));
          check(e.tag, "exe_npc", ifc.exe_npc, e.npc);
          check(e.tag, "alu1", ifc.exe_alu1, e.alu1);
          check(e.tag, "alu2", ifc.exe_alu2, e.alu2);
        end
        if (e.chk_addr) check(e.tag, "addr", ifc.exe_addr, e.addr);
        if (e.chk_tgt) check(e.tag, "target", ifc.exe_tgt, e.tgt);
      end
    end
  end

  initial begin : stim
    ins_t        in;
    logic [63:0] n;
    ill_ops = '{7'b1111111, 7'b0001111, 7'b1110011, 7'b0000000};
    for (int i = 0; i < 32; i++) rf[i] = '0;
    RESET       = 1'b1;
    ifc.de_v    = 1'b0;
    ifc.de_ir   = '0;
    ifc.de_npc  = '0;
    ifc.wb_wen  = 1'b0;
    ifc.wb_dr   = '0;
    ifc.wb_data = '0;
    ifc.exe_dr  = '0;
    ifc.mem_dr  = '0;

    in = '{k: K_OPI, rd: 5'd0, rs1: 5'd0, rs2: 5'd0, imm: 64'd0};
    issue(1, 0, in, 64'h0, 0, 0, 0, 0, 0, "reset");
    issue(1, 1, in, 64'h4, 0, 0, 0, 0, 0, "reset2");

    in = '{k: K_OPI, rd: 5'd6, rs1: 5'd5, rs2: 5'd0, imm: 64'd1};
    issue(0, 1, in, 64'h1000, 1, 5'd5, 64'h1234, 0, 0, "wthru");
    in = '{k: K_OPI, rd: 5'd7, rs1: 5'd5, rs2: 5'd0, imm: 64'd0};
    issue(0, 1, in, 64'h1004, 0, 0, 0, 0, 0, "rf_read");

    in = '{k: K_OP, rd: 5'd8, rs1: 5'd7, rs2: 5'd1, imm: 64'd0};
    issue(0, 1, in, 64'h1008, 0, 0, 0, 5'd7, 0, "raw_stall");
    issue(0, 1, in, 64'h1008, 0, 0, 0, 5'd0, 0, "raw_go");
    issue(0, 1, in, 64'h1008, 0, 0, 0, 5'd0, 5'd1, "raw_mem");

    in = '{k: K_BR, rd: 5'd0, rs1: 5'd1, rs2: 5'd2, imm: -64'sd8};
    issue(0, 1, in, 64'h104, 0, 0, 0, 0, 0, "beq");

    in = '{k: K_JALR, rd: 5'd1, rs1: 5'd3, rs2: 5'd0, imm: 64'd4};
    issue(0, 1, in, 64'h2000, 1, 5'd3, 64'h2001, 0, 0, "jalr");

    in = '{k: K_ILL, rd: 5'd0, rs1: 5'd0, rs2: 5'd0, imm: 64'h155};
    issue(0, 1, in, 64'h3000, 0, 0, 0, 0, 0, "illegal");
    in = '{k: K_LD, rd: 5'd2, rs1: 5'd3, rs2: 5'd0, imm: 64'd16};
    issue(0, 0, in, 64'h3004, 0, 0, 0, 0, 0, "no_valid");

    for (int t = 0; t < 400; t++) begin
      in.k   = kind_e'($urandom_range(0, 11));
      in.rd  = rr();
      in.rs1 = rr();
      in.rs2 = rr();
      in.imm = rand_imm(in.k);
      n = {32'($urandom), 32'($urandom)} & ~64'h3;
      issue($urandom_range(0, 99) == 0, $urandom_range(0, 7) != 0, in, n,
            $urandom_range(0, 1) == 1, rr(),
            {32'($urandom), 32'($urandom)},
            ($urandom_range(0, 2) == 0) ? rr() : 5'd0,
            ($urandom_range(0, 2) == 0) ? rr() : 5'd0,
            "rand", ill_ops[$urandom_range(0, 3)]);
    end

    in = '{k: K_OP, rd: 5'd8, rs1: 5'd7, rs2: 5'd1, imm: 64'd0};
    issue(0, 1, in, 64'h5008, 0, 0, 0, 5'd7, 0, "pre_rst_stall");
    issue(1, 1, in, 64'h5008, 1, 5'd9, 64'hdead, 5'd7, 0, "rst_stall");
    for (int i = 1; i < 32; i++) begin
      in = '{k: K_OPI, rd: 5'd1, rs1: 5'(i), rs2: 5'd0, imm: 64'd0};
      issue(0, 1, in, 64'h6000, 0, 0, 0, 0, 0, "rd_zero");
    end
    in = '{k: K_OPI, rd: 5'd1, rs1: 5'd0, rs2: 5'd0, imm: 64'd0};
    issue(0, 1, in, 64'h7000, 1, 5'd0, 64'hffff, 0, 0, "x0_wr");
    issue(0, 1, in, 64'h7004, 0, 0, 0, 0, 0, "x0_rd");

    @(negedge CLK);
    ifc.de_v = 1'b0;
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge CLK);
    #3;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain pending=%0d expected=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
